exibe_sequencia: RTL and testbench
==================================

Name: exibe_sequencia

Overview:
Playback side of the memory-game protocol. The control unit reads player input (jogada) and compares it against stored RAM; this block does the opposite: it reads the stored sequence from the same RAM and shows it to the player on the LEDs. It runs from address 0 up to the current round, with fixed on and off times per item. The top-level control unit starts it with a pulse at the start of each round and waits for its one-cycle completion pulse before entering the player wait state.

Parameters:
ADDR_W, 4, width of RAM address and round number
DATA_W, 4, width of RAM data and LED vector (one-hot per button)
T_ACESO, 500, clock cycles each item is lit; must be >= 1
T_APAGADO, 250, clock cycles LEDs stay dark after each item; must be >= 1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iniciar  in  1  start pulse; sampled only in ocioso
cancela  in  1  abort; forces return to ocioso
rodada  in  ADDR_W  last address to show (round index; shows rodada+1 items)
dado_mem  in  DATA_W  RAM read data; valid one cycle after endereco is driven
endereco  out  ADDR_W  RAM read address
leds  out  DATA_W  LED drive
exibindo  out  1  high in every state except ocioso
fim  out  1  one-cycle pulse when playback finishes
db_estado  out  4  debug state code

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high. On reset: state=ocioso, endereco=0, leds=0, exibindo=0, fim=0, timer=0, db_estado=0.
- Registers: address counter end_cnt (ADDR_W), data register dado_reg (DATA_W), timer (wide enough for max(T_ACESO,T_APAGADO)). `rodada` is latched into rodada_reg when iniciar is accepted, so later changes do not matter.
- States and debug codes:
  - ocioso (0): end_cnt=0, leds=0. If iniciar=1, go to carrega.
  - carrega (1): endereco=end_cnt; go to registra.
  - registra (2): dado_reg<=dado_mem; timer zeroed; go to acende.
  - acende (3): leds=dado_reg; timer counts. After exactly T_ACESO cycles in this state, zero the timer and go to apaga.
  - apaga (4): leds=0; timer counts. After exactly T_APAGADO cycles: if end_cnt==rodada_reg go to concluido; otherwise end_cnt++ and go to carrega.
  - concluido (5): fim=1 for this single cycle; go to ocioso.
  - Any unused encoding goes to ocioso, with db_estado=F.
- Outputs are Moore outputs, registered or decoded from state only. endereco always equals end_cnt.
- Cycle budget: with iniciar high in cycle 0, each item takes 2+T_ACESO+T_APAGADO cycles. concluido occurs in cycle 1+N·(2+T_ACESO+T_APAGADO), where N=rodada+1.
- Boundaries:
  - rodada=0: exactly one item is shown.
  - rodada=2^ADDR_W−1: all addresses are shown. end_cnt never wraps because the comparison ends playback first.
- Simultaneous or interrupting events:
  - iniciar while not in ocioso is ignored.
  - cancela has priority over every transition, including iniciar in ocioso. It sends the state to ocioso on the next edge with leds=0 and end_cnt=0, and fim is not pulsed.
  - reset has priority over cancela. Reset mid-playback gives full reset values on the next edge.
- dado_mem is not sampled in any state except registra.

Decomposition:
- Shared package: state encodings (ocioso..concluido as 4-bit constants, matching the db_estado codes above) and the default ADDR_W/DATA_W values, so the top-level control unit and this block agree.
- Natural sub-module: temporizador_exibicao, a counter with zera/conta inputs and parameter M that raises fim_tempo when count==M−1. It is instantiated once; the FSM selects T_ACESO or T_APAGADO as the limit. Alternatively, two instances can be used.

Test Plan:
1. T_ACESO=4, T_APAGADO=2, rodada=0, mem[0]=0010, iniciar in cycle 0 → leds=0010 in cycles 3–6, leds=0 in cycles 7–8, fim=1 only in cycle 9, exibindo=1 in cycles 1–9, back in ocioso in cycle 10.
2. Same parameters, rodada=2, mem={0001,0100,1000} → endereco goes 0,1,2 and leds show 0001, 0100, 1000 in order, each lit 4 cycles; fim pulses in cycle 25 exactly once.
3. rodada=15, mem[i]=i → all 16 addresses are shown, endereco never exceeds 15, fim pulses in cycle 129.
4. cancela=1 during the second item's acende → next cycle: ocioso, leds=0, endereco=0, no fim pulse. A new iniciar restarts from address 0.
5. reset=1 in the apaga state, then iniciar pulsed during playback and rodada changed mid-run → after reset all outputs are 0. In a separate run, the extra iniciar is ignored and the item count follows the latched rodada.
6. iniciar and cancela both high in ocioso → the block stays in ocioso with exibindo=0.

Source files
------------

// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the memory-game playback block and the control unit that drives it.
package exibe_sequencia_pkg;

  localparam int unsigned ADDR_W_PADRAO = 4;
  localparam int unsigned DATA_W_PADRAO = 4;

  // Encodings double as the db_estado debug codes.
  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CARREGA   = 4'd1,
    REGISTRA  = 4'd2,
    ACENDE    = 4'd3,
    APAGA     = 4'd4,
    CONCLUIDO = 4'd5
  } estado_t;

  localparam logic [3:0] CODIGO_INVALIDO = 4'hF;

  function automatic logic [3:0] codigoEstado(input estado_t e);
    case (e)
      OCIOSO, CARREGA, REGISTRA, ACENDE, APAGA, CONCLUIDO: codigoEstado = 4'(e);
      default:                                             codigoEstado = CODIGO_INVALIDO;
    endcase
  endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Dwell timer: counts while conta is high, fim_tempo marks the M-th counted cycle.
module temporizador_exibicao #(
  parameter int unsigned M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_tempo
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + W'(1);
    end
  end

  assign fim_tempo = conta && (contagem == W'(M - 1));

endmodule

// File: rtl/exibe_sequencia.sv
// Plays the stored sequence (addresses 0..rodada) on the LEDs with fixed on/off times.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_PADRAO,
  parameter int unsigned DATA_W    = DATA_W_PADRAO,
  parameter int unsigned T_ACESO   = 500,
  parameter int unsigned T_APAGADO = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cancela,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              fim,
  output logic [3:0]        db_estado
);

  estado_t           estado;
  logic [ADDR_W-1:0] endCnt;
  logic [ADDR_W-1:0] rodadaReg;
  logic [DATA_W-1:0] dadoReg;
  logic              fimAceso;
  logic              fimApagado;

  temporizador_exibicao #(.M(T_ACESO)) timerAceso (
    .clock     (clock),
    .reset     (reset),
    .zera      (estado != ACENDE),
    .conta     (estado == ACENDE),
    .fim_tempo (fimAceso)
  );

  temporizador_exibicao #(.M(T_APAGADO)) timerApagado (
    .clock     (clock),
    .reset     (reset),
    .zera      (estado != APAGA),
    .conta     (estado == APAGA),
    .fim_tempo (fimApagado)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      endCnt    <= '0;
      rodadaReg <= '0;
      dadoReg   <= '0;
      exibindo  <= 1'b0;
      fim       <= 1'b0;
    end else if (cancela) begin
      estado   <= OCIOSO;
      endCnt   <= '0;
      exibindo <= 1'b0;
      fim      <= 1'b0;
    end else begin
      fim <= 1'b0;
      case (estado)
        OCIOSO: begin
          endCnt <= '0;
          if (iniciar) begin
            rodadaReg <= rodada;
            exibindo  <= 1'b1;
            estado    <= CARREGA;
          end
        end
        CARREGA: estado <= REGISTRA;
        REGISTRA: begin
          dadoReg <= dado_mem;
          estado  <= ACENDE;
        end
        ACENDE: begin
          if (fimAceso) estado <= APAGA;
        end
        APAGA: begin
          if (fimApagado) begin
            // The round comparison ends playback before endCnt could wrap.
            if (endCnt == rodadaReg) begin
              fim    <= 1'b1;
              estado <= CONCLUIDO;
            end else begin
              endCnt <= endCnt + ADDR_W'(1);
              estado <= CARREGA;
            end
          end
        end
        CONCLUIDO: begin
          endCnt   <= '0;
          exibindo <= 1'b0;
          estado   <= OCIOSO;
        end
        default: begin
          endCnt   <= '0;
          exibindo <= 1'b0;
          estado   <= OCIOSO;
        end
      endcase
    end
  end

  assign endereco  = endCnt;
  assign leds      = (estado == ACENDE) ? dadoReg : '0;
  assign db_estado = codigoEstado(estado);

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia against a cycle-timeline reference model.
module tb_exibe_sequencia;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned TA = 4;
  localparam int unsigned TP = 2;
  localparam int P = 2 + TA + TP;

  logic          clock = 1'b0;
  logic          reset;
  logic          iniciar;
  logic          cancela;
  logic [AW-1:0] rodada;
  logic [DW-1:0] dado_mem;
  logic [AW-1:0] endereco;
  logic [DW-1:0] leds;
  logic          exibindo;
  logic          fim;
  logic [3:0]    db_estado;

  logic [DW-1:0] mem [16];
  int nTests = 0;
  int nFail  = 0;

  always #5 clock = ~clock;

  // Synchronous RAM: data appears one cycle after the address.
  always @(posedge clock) dado_mem <= mem[endereco];

  exibe_sequencia #(
    .ADDR_W(AW), .DATA_W(DW), .T_ACESO(TA), .T_APAGADO(TP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .cancela   (cancela),
    .rodada    (rodada),
    .dado_mem  (dado_mem),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .fim       (fim),
    .db_estado (db_estado)
  );

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Starts a playback in cycle 0 and checks every cycle until back in idle.
  task automatic playAndCheck(input int r, input bit noisy, input string nome);
    int n = r + 1;
    int last = n * P + 2;
    rodada  = AW'(r);
    iniciar = 1'b1;
    stepCycle();
    iniciar = 1'b0;
    for (int c = 1; c <= last; c++) begin
      int k;
      int o;
      logic [DW-1:0] eLeds;
      logic [AW-1:0] eEnd;
      logic          eExib;
      logic          eFim;
      logic [3:0]    eDb;
      if (c <= n * P) begin
        k     = (c - 1) / P;
        o     = (c - 1) % P;
        eEnd  = AW'(k);
        eExib = 1'b1;
        eFim  = 1'b0;
        eLeds = (o >= 2 && o < 2 + int'(TA)) ? mem[k] : '0;
        eDb   = (o == 0) ? 4'd1 : (o == 1) ? 4'd2 : (o < 2 + int'(TA)) ? 4'd3 : 4'd4;
      end else if (c == n * P + 1) begin
        eEnd = AW'(r); eExib = 1'b1; eFim = 1'b1; eLeds = '0; eDb = 4'd5;
      end else begin
        eEnd = '0; eExib = 1'b0; eFim = 1'b0; eLeds = '0; eDb = 4'd0;
      end
      nTests++;
      if (leds !== eLeds) begin
        nFail++;
        $display("FAIL %s leds cycle %0d: got %b expected %b", nome, c, leds, eLeds);
      end
      nTests++;
      if (endereco !== eEnd) begin
        nFail++;
        $display("FAIL %s endereco cycle %0d: got %0d expected %0d", nome, c, endereco, eEnd);
      end
      nTests++;
      if (exibindo !== eExib) begin
        nFail++;
        $display("FAIL %s exibindo cycle %0d: got %b expected %b", nome, c, exibindo, eExib);
      end
      nTests++;
      if (fim !== eFim) begin
        nFail++;
        $display("FAIL %s fim cycle %0d: got %b expected %b", nome, c, fim, eFim);
      end
      nTests++;
      if (db_estado !== eDb) begin
        nFail++;
        $display("FAIL %s db_estado cycle %0d: got %0d expected %0d", nome, c, db_estado, eDb);
      end
      if (noisy && c <= n * P) begin
        iniciar = 1'($urandom_range(0, 1));
        rodada  = AW'($urandom);
      end else begin
        iniciar = 1'b0;
      end
      if (c < last) stepCycle();
    end
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; cancela = 1'b0; rodada = '0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    nTests++;
    if ({leds, endereco, exibindo, fim, db_estado} !== '0) begin
      nFail++;
      $display("FAIL reset outputs: leds=%b end=%0d exib=%b fim=%b db=%0d expected all zero",
               leds, endereco, exibindo, fim, db_estado);
    end
    stepCycle();
  endtask

  task automatic test_single();
    mem[0] = 4'b0010;
    playAndCheck(0, 1'b0, "single");
  endtask

  task automatic test_three();
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    playAndCheck(2, 1'b0, "three");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    playAndCheck(15, 1'b0, "full");
  endtask

  task automatic test_random();
    logic [DW-1:0] um = DW'(1);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = um << $urandom_range(0, DW - 1);
      playAndCheck(int'($urandom_range(0, 5)), 1'b1, "random");
    end
  endtask

  task automatic test_cancel();
    for (int i = 0; i < 16; i++) mem[i] = 4'b0100;
    mem[0] = 4'b0001;
    mem[1] = 4'b1000;
    rodada = AW'(3); iniciar = 1'b1;
    stepCycle();
    iniciar = 1'b0;
    for (int c = 1; c < P + 3; c++) stepCycle();
    nTests++;
    if (leds !== mem[1]) begin
      nFail++;
      $display("FAIL cancel second item lit: got %b expected %b", leds, mem[1]);
    end
    cancela = 1'b1;
    stepCycle();
    cancela = 1'b0;
    nTests++;
    if ({leds, endereco, exibindo, fim, db_estado} !== '0) begin
      nFail++;
      $display("FAIL cancel idle: leds=%b end=%0d exib=%b fim=%b db=%0d expected all zero",
               leds, endereco, exibindo, fim, db_estado);
    end
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      nTests++;
      if (fim !== 1'b0 || exibindo !== 1'b0) begin
        nFail++;
        $display("FAIL cancel stays idle: fim=%b exib=%b expected 0 0", fim, exibindo);
      end
    end
    playAndCheck(1, 1'b0, "restart");
  endtask

  task automatic test_reset_mid();
    mem[0] = 4'b0010; mem[1] = 4'b0001; mem[2] = 4'b0100;
    rodada = AW'(2); iniciar = 1'b1;
    stepCycle();
    iniciar = 1'b0;
    for (int c = 1; c < 2 + int'(TA) + 1; c++) stepCycle();
    nTests++;
    if (db_estado !== 4'd4) begin
      nFail++;
      $display("FAIL reset_mid in apaga: got db %0d expected 4", db_estado);
    end
    reset = 1'b1; iniciar = 1'b1; cancela = 1'b1;
    stepCycle();
    reset = 1'b0; iniciar = 1'b0; cancela = 1'b0;
    nTests++;
    if ({leds, endereco, exibindo, fim, db_estado} !== '0) begin
      nFail++;
      $display("FAIL reset_mid outputs: leds=%b end=%0d exib=%b fim=%b db=%0d expected all zero",
               leds, endereco, exibindo, fim, db_estado);
    end
    stepCycle();
    nTests++;
    if (exibindo !== 1'b0) begin
      nFail++;
      $display("FAIL reset_mid stays idle: exib=%b expected 0", exibindo);
    end
    playAndCheck(2, 1'b1, "latched");
  endtask

  task automatic test_both();
    iniciar = 1'b1; cancela = 1'b1; rodada = AW'(1);
    stepCycle();
    iniciar = 1'b0; cancela = 1'b0;
    nTests++;
    if (exibindo !== 1'b0 || db_estado !== 4'd0) begin
      nFail++;
      $display("FAIL both idle: exib=%b db=%0d expected 0 0", exibindo, db_estado);
    end
    stepCycle();
    nTests++;
    if (exibindo !== 1'b0 || db_estado !== 4'd0) begin
      nFail++;
      $display("FAIL both later: exib=%b db=%0d expected 0 0", exibindo, db_estado);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_three();
    test_full();
    test_random();
    test_cancel();
    test_reset_mid();
    test_both();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
